// File: rtl/atomrvcore_decode_stage_if.sv
// Fetch, write-back and execute-side signals of the decode stage, grouped as one bundle.
// No logic and no latency of its own; it only carries signals.
// Flow control is valid/ready on both the fetch side and the execute side.
interface atomrvcore_decode_stage_if #(
  parameter int DATAWIDTH = 32
);
  logic                 flush_i;
  logic                 instr_valid_i;
  logic [31:0]          instr_i;
  logic [DATAWIDTH-1:0] pc_i;
  logic                 instr_ready_o;
  logic                 wb_en_i;
  logic [4:0]           wb_rd_i;
  logic [DATAWIDTH-1:0] wb_data_i;
  logic                 dec_valid_o;
  logic                 ex_ready_i;
  logic [DATAWIDTH-1:0] pc_o;
  logic [DATAWIDTH-1:0] rs1_data_o;
  logic [DATAWIDTH-1:0] rs2_data_o;
  logic [DATAWIDTH-1:0] imm_o;
  logic [4:0]           rd_o;
  logic                 rd_we_o;
  logic [5:0]           alu_op_o;
  logic                 op_b_imm_o;
  logic                 mem_rd_o;
  logic                 mem_wr_o;
  logic [2:0]           mem_size_o;
  logic                 branch_o;
  logic                 jal_o;
  logic                 jalr_o;
  logic                 lui_o;
  logic                 auipc_o;
  logic                 illegal_o;

  // Fetch / write-back / execute side of the stage.
  modport master (
    output flush_i, instr_valid_i, instr_i, pc_i, wb_en_i, wb_rd_i, wb_data_i, ex_ready_i,
    input  instr_ready_o, dec_valid_o, pc_o, rs1_data_o, rs2_data_o, imm_o, rd_o, rd_we_o,
           alu_op_o, op_b_imm_o, mem_rd_o, mem_wr_o, mem_size_o, branch_o, jal_o, jalr_o,
           lui_o, auipc_o, illegal_o
  );

  // The decode stage itself.
  modport slave (
    input  flush_i, instr_valid_i, instr_i, pc_i, wb_en_i, wb_rd_i, wb_data_i, ex_ready_i,
    output instr_ready_o, dec_valid_o, pc_o, rs1_data_o, rs2_data_o, imm_o, rd_o, rd_we_o,
           alu_op_o, op_b_imm_o, mem_rd_o, mem_wr_o, mem_size_o, branch_o, jal_o, jalr_o,
           lui_o, auipc_o, illegal_o
  );
endinterface

// File: rtl/atomrvcore_decode_stage.sv
// RV32I/RV32E decode stage: register file with write-back bypass, decoder and one output register.
// Latency: one cycle from accept to dec_valid_o.
// Backpressure: instr_ready_o drops when the output register is full and ex_ready_i is low, on load-use hazard, or on flush.
module atomrvcore_decode_stage #(
  parameter int DATAWIDTH      = 32,
  parameter int NUM_REGS       = 32,
  parameter bit WB_BYPASS      = 1'b1,
  parameter bit LOAD_USE_STALL = 1'b1
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  atomrvcore_decode_stage_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LD = 7'h03, OP_ST = 7'h23, OP_BR = 7'h63,
                         OP_JALR = 7'h67, OP_JAL = 7'h6F, OP_LUI = 7'h37, OP_AUIPC = 7'h17;
  localparam logic [5:0] A_ADD = 6'd1, A_SLL = 6'd2, A_SLT = 6'd3, A_SLTU = 6'd4, A_XOR = 6'd5,
                         A_SRL = 6'd6, A_SRA = 6'd7, A_OR = 6'd8, A_AND = 6'd9, A_SUB = 6'd10,
                         A_BEQ = 6'd11, A_BNE = 6'd12, A_BLT = 6'd13, A_BGE = 6'd14,
                         A_BLTU = 6'd15, A_BGEU = 6'd16, A_JAL = 6'd17;

  typedef enum logic {EMPTY, FULL} state_e;
  state_e state_q, state_d;

  logic [DATAWIDTH-1:0] rf [NUM_REGS];
  logic [31:0] instr;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1_a, rs2_a, rd_a;
  logic        wb_wr, accept, transfer, hazard;
  logic [DATAWIDTH-1:0] rs1_rd, rs2_rd;

  // decoded fields of instr_i
  logic signed [31:0] d_imm;
  logic [5:0] d_alu;
  logic [2:0] d_msz;
  logic d_ill, d_opb, d_mrd, d_mwr, d_br, d_jal, d_jalr, d_lui, d_auipc;
  logic has_rd, use_rs1, use_rs2, d_rd_we;

  // output register and its source addresses (kept for refresh)
  logic [DATAWIDTH-1:0] pc_q, rs1_q, rs2_q, imm_q;
  logic [4:0] rd_q, rs1_a_q, rs2_a_q, lu_rd_q;
  logic [5:0] alu_q;
  logic [2:0] msz_q;
  logic rd_we_q, opb_q, mrd_q, mwr_q, br_q, jal_q, jalr_q, lui_q, auipc_q, ill_q, lu_vld_q;

  assign instr  = bus.instr_i;
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign rs1_a  = instr[19:15];
  assign rs2_a  = instr[24:20];
  assign rd_a   = instr[11:7];

  assign wb_wr    = bus.wb_en_i && (bus.wb_rd_i != 5'd0) && (32'(bus.wb_rd_i) < NUM_REGS);
  assign transfer = (state_q == FULL) && bus.ex_ready_i;
  assign hazard   = LOAD_USE_STALL && lu_vld_q &&
                    ((use_rs1 && rs1_a == lu_rd_q) || (use_rs2 && rs2_a == lu_rd_q));
  assign bus.instr_ready_o = rst_ni && ((state_q == EMPTY) || bus.ex_ready_i) && !hazard && !bus.flush_i;
  assign accept   = bus.instr_valid_i && bus.instr_ready_o;

  // Register file; x0 is never written so entry 0 stays zero after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wb_wr) begin
      rf[bus.wb_rd_i[AW-1:0]] <= bus.wb_data_i;
    end
  end

  // Operand read with optional same-cycle write-back forwarding.
  always_comb begin
    rs1_rd = '0;
    rs2_rd = '0;
    if (rs1_a != 5'd0) begin
      if (WB_BYPASS && wb_wr && bus.wb_rd_i == rs1_a) rs1_rd = bus.wb_data_i;
      else if (32'(rs1_a) < NUM_REGS)                rs1_rd = rf[rs1_a[AW-1:0]];
    end
    if (rs2_a != 5'd0) begin
      if (WB_BYPASS && wb_wr && bus.wb_rd_i == rs2_a) rs2_rd = bus.wb_data_i;
      else if (32'(rs2_a) < NUM_REGS)                rs2_rd = rf[rs2_a[AW-1:0]];
    end
  end

  function automatic logic [5:0] alu_of(input logic [2:0] fn3, input logic alt);
    case (fn3)
      3'd0:    alu_of = alt ? A_SUB : A_ADD;
      3'd1:    alu_of = A_SLL;
      3'd2:    alu_of = A_SLT;
      3'd3:    alu_of = A_SLTU;
      3'd4:    alu_of = A_XOR;
      3'd5:    alu_of = alt ? A_SRA : A_SRL;
      3'd6:    alu_of = A_OR;
      default: alu_of = A_AND;
    endcase
  endfunction

  // Instruction decode; illegal encodings suppress every side-effecting flag.
  always_comb begin
    d_ill = 1'b0; d_alu = '0; d_imm = '0; d_opb = 1'b0; d_mrd = 1'b0; d_mwr = 1'b0; d_msz = '0;
    d_br = 1'b0; d_jal = 1'b0; d_jalr = 1'b0; d_lui = 1'b0; d_auipc = 1'b0;
    has_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        has_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        d_alu = alu_of(f3, f7[5]);
        if (f7 != 7'h00 && f7 != 7'h20) d_ill = 1'b1;
        if (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) d_ill = 1'b1;
      end
      OP_I: begin
        has_rd = 1'b1; use_rs1 = 1'b1; d_opb = 1'b1;
        d_imm = {{20{instr[31]}}, instr[31:20]};
        d_alu = (f3 == 3'd0) ? A_ADD : alu_of(f3, f7[5]);
        if (f3 == 3'd1 && f7 != 7'h00) d_ill = 1'b1;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) d_ill = 1'b1;
      end
      OP_LD: begin
        has_rd = 1'b1; use_rs1 = 1'b1; d_opb = 1'b1; d_mrd = 1'b1; d_msz = f3; d_alu = A_ADD;
        d_imm = {{20{instr[31]}}, instr[31:20]};
      end
      OP_ST: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; d_opb = 1'b1; d_mwr = 1'b1; d_msz = f3; d_alu = A_ADD;
        d_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BR: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; d_br = 1'b1;
        d_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        case (f3)
          3'd0: d_alu = A_BEQ;
          3'd1: d_alu = A_BNE;
          3'd4: d_alu = A_BLT;
          3'd5: d_alu = A_BGE;
          3'd6: d_alu = A_BLTU;
          3'd7: d_alu = A_BGEU;
          default: d_ill = 1'b1;
        endcase
      end
      OP_JALR: begin
        has_rd = 1'b1; use_rs1 = 1'b1; d_opb = 1'b1; d_jalr = 1'b1; d_alu = A_ADD;
        d_imm = {{20{instr[31]}}, instr[31:20]};
      end
      OP_JAL: begin
        has_rd = 1'b1; d_jal = 1'b1; d_alu = A_JAL;
        d_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_LUI: begin
        has_rd = 1'b1; d_opb = 1'b1; d_lui = 1'b1; d_alu = A_ADD;
        d_imm = {instr[31:12], 12'b0};
      end
      OP_AUIPC: begin
        has_rd = 1'b1; d_opb = 1'b1; d_auipc = 1'b1; d_alu = A_ADD;
        d_imm = {instr[31:12], 12'b0};
      end
      default: d_ill = 1'b1;
    endcase
    if (NUM_REGS < 32 && ((use_rs1 && rs1_a[4]) || (use_rs2 && rs2_a[4]) || (has_rd && rd_a[4])))
      d_ill = 1'b1;
    if (d_ill) begin
      d_alu = '0; d_mrd = 1'b0; d_mwr = 1'b0; d_br = 1'b0; d_jal = 1'b0; d_jalr = 1'b0;
    end
  end

  assign d_rd_we = has_rd && (rd_a != 5'd0) && !d_ill;

  // Output-register state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  // Next state; flush wins over accept and transfer.
  always_comb begin
    state_d = state_q;
    if (bus.flush_i) state_d = EMPTY;
    else if (state_q == EMPTY) begin
      if (accept) state_d = FULL;
    end else if (transfer && !accept) state_d = EMPTY;
  end

  // Load-use window: armed for exactly one cycle after a load leaves the stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lu_vld_q <= 1'b0;
      lu_rd_q  <= '0;
    end else begin
      lu_vld_q <= !bus.flush_i && transfer && mrd_q && (rd_q != 5'd0);
      lu_rd_q  <= rd_q;
    end
  end

  // Capture decoded instruction on accept; otherwise keep held operands current with write-backs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= '0; rs1_q <= '0; rs2_q <= '0; imm_q <= '0; rd_q <= '0; rs1_a_q <= '0; rs2_a_q <= '0;
      alu_q <= '0; msz_q <= '0; rd_we_q <= 1'b0; opb_q <= 1'b0; mrd_q <= 1'b0; mwr_q <= 1'b0;
      br_q <= 1'b0; jal_q <= 1'b0; jalr_q <= 1'b0; lui_q <= 1'b0; auipc_q <= 1'b0; ill_q <= 1'b0;
    end else if (accept) begin
      pc_q <= bus.pc_i; rs1_q <= rs1_rd; rs2_q <= rs2_rd; imm_q <= DATAWIDTH'(d_imm);
      rd_q <= rd_a; rs1_a_q <= rs1_a; rs2_a_q <= rs2_a; alu_q <= d_alu; msz_q <= d_msz;
      rd_we_q <= d_rd_we; opb_q <= d_opb; mrd_q <= d_mrd; mwr_q <= d_mwr; br_q <= d_br;
      jal_q <= d_jal; jalr_q <= d_jalr; lui_q <= d_lui; auipc_q <= d_auipc; ill_q <= d_ill;
    end else if (state_q == FULL && !transfer && wb_wr) begin
      if (bus.wb_rd_i == rs1_a_q) rs1_q <= bus.wb_data_i;
      if (bus.wb_rd_i == rs2_a_q) rs2_q <= bus.wb_data_i;
    end
  end

  assign bus.dec_valid_o = (state_q == FULL);
  assign bus.pc_o        = pc_q;
  assign bus.rs1_data_o  = rs1_q;
  assign bus.rs2_data_o  = rs2_q;
  assign bus.imm_o       = imm_q;
  assign bus.rd_o        = rd_q;
  assign bus.rd_we_o     = rd_we_q;
  assign bus.alu_op_o    = alu_q;
  assign bus.op_b_imm_o  = opb_q;
  assign bus.mem_rd_o    = mrd_q;
  assign bus.mem_wr_o    = mwr_q;
  assign bus.mem_size_o  = msz_q;
  assign bus.branch_o    = br_q;
  assign bus.jal_o       = jal_q;
  assign bus.jalr_o      = jalr_q;
  assign bus.lui_o       = lui_q;
  assign bus.auipc_o     = auipc_q;
  assign bus.illegal_o   = ill_q;
endmodule

// File: tb/tb_atomrvcore_decode_stage.sv
// Directed bench for the decode stage: RV32I instance plus an RV32E instance sharing clock and reset.
// Inputs change 1 ns after the rising edge; outputs are compared away from the edge.
// Execute-side backpressure is driven explicitly through ex_ready_i in each scenario.
module tb_atomrvcore_decode_stage;
  logic clk_i = 1'b0;
  logic rst_ni;
  int total = 0;
  int bad = 0;

  atomrvcore_decode_stage_if #(.DATAWIDTH(32)) b();
  atomrvcore_decode_stage_if #(.DATAWIDTH(32)) e();

  always #5 clk_i = ~clk_i;

  atomrvcore_decode_stage #(.DATAWIDTH(32), .NUM_REGS(32), .WB_BYPASS(1'b1), .LOAD_USE_STALL(1'b1))
    dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(b));
  atomrvcore_decode_stage #(.DATAWIDTH(32), .NUM_REGS(16), .WB_BYPASS(1'b1), .LOAD_USE_STALL(1'b1))
    dut_e (.clk_i(clk_i), .rst_ni(rst_ni), .bus(e));

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    b.flush_i = 0; b.instr_valid_i = 0; b.instr_i = '0; b.pc_i = '0; b.wb_en_i = 0;
    b.wb_rd_i = '0; b.wb_data_i = '0; b.ex_ready_i = 0;
    e.flush_i = 0; e.instr_valid_i = 0; e.instr_i = '0; e.pc_i = '0; e.wb_en_i = 0;
    e.wb_rd_i = '0; e.wb_data_i = '0; e.ex_ready_i = 0;
    rst_ni = 1; #2 rst_ni = 0; #10;
    total++; if (b.instr_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", b.instr_ready_o); end
    total++; if (b.dec_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", b.dec_valid_o); end
    total++; if (b.imm_o !== 32'd0 || b.rs1_data_o !== 32'd0 || b.rd_we_o !== 1'b0 || b.illegal_o !== 1'b0)
      begin bad++; $display("FAIL reset_outputs imm=%h rs1=%h we=%b ill=%b want all 0", b.imm_o, b.rs1_data_o, b.rd_we_o, b.illegal_o); end
    @(negedge clk_i) rst_ni = 1;
    #1;
    total++; if (b.instr_ready_o !== 1'b1) begin bad++; $display("FAIL release_ready got=%b want=1", b.instr_ready_o); end
    cyc();
  endtask

  task automatic test_addi();
    b.instr_i = 32'h00500093; b.pc_i = 32'h100; b.instr_valid_i = 1; b.ex_ready_i = 0;
    cyc();
    b.instr_valid_i = 0;
    total++; if (b.dec_valid_o !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b want=1", b.dec_valid_o); end
    total++; if (b.imm_o !== 32'd5 || b.rd_o !== 5'd1 || b.pc_o !== 32'h100)
      begin bad++; $display("FAIL addi_fields imm=%h rd=%0d pc=%h want 5/1/100", b.imm_o, b.rd_o, b.pc_o); end
    total++; if (b.rd_we_o !== 1'b1 || b.alu_op_o !== 6'd1 || b.op_b_imm_o !== 1'b1 || b.illegal_o !== 1'b0)
      begin bad++; $display("FAIL addi_ctrl we=%b alu=%0d opb=%b ill=%b want 1/1/1/0", b.rd_we_o, b.alu_op_o, b.op_b_imm_o, b.illegal_o); end
    b.ex_ready_i = 1; cyc(); b.ex_ready_i = 0;
    total++; if (b.dec_valid_o !== 1'b0) begin bad++; $display("FAIL addi_drain got=%b want=0", b.dec_valid_o); end
  endtask

  task automatic test_operand_read();
    b.wb_en_i = 1; b.wb_rd_i = 5'd1; b.wb_data_i = 32'h11; cyc();
    b.wb_rd_i = 5'd2; b.wb_data_i = 32'h22; cyc();
    b.wb_en_i = 0; b.instr_i = 32'h002081B3; b.instr_valid_i = 1; cyc();
    b.instr_valid_i = 0;
    total++; if (b.rs1_data_o !== 32'h11 || b.rs2_data_o !== 32'h22)
      begin bad++; $display("FAIL rf_read rs1=%h rs2=%h want 11/22", b.rs1_data_o, b.rs2_data_o); end
    total++; if (b.rd_o !== 5'd3 || b.alu_op_o !== 6'd1 || b.op_b_imm_o !== 1'b0)
      begin bad++; $display("FAIL add_ctrl rd=%0d alu=%0d opb=%b want 3/1/0", b.rd_o, b.alu_op_o, b.op_b_imm_o); end
    b.ex_ready_i = 1; cyc(); b.ex_ready_i = 0;
    b.instr_valid_i = 1; b.wb_en_i = 1; b.wb_rd_i = 5'd2; b.wb_data_i = 32'h33; cyc();
    b.instr_valid_i = 0; b.wb_en_i = 0;
    total++; if (b.rs1_data_o !== 32'h11 || b.rs2_data_o !== 32'h33)
      begin bad++; $display("FAIL bypass rs1=%h rs2=%h want 11/33", b.rs1_data_o, b.rs2_data_o); end
  endtask

  task automatic test_refresh();
    b.wb_en_i = 1; b.wb_rd_i = 5'd1; b.wb_data_i = 32'h99; cyc();
    total++; if (b.rs1_data_o !== 32'h99 || b.rs2_data_o !== 32'h33 || b.dec_valid_o !== 1'b1)
      begin bad++; $display("FAIL refresh rs1=%h rs2=%h vld=%b want 99/33/1", b.rs1_data_o, b.rs2_data_o, b.dec_valid_o); end
    b.wb_rd_i = 5'd7; b.wb_data_i = 32'h77; cyc();
    b.wb_en_i = 0;
    total++; if (b.rs1_data_o !== 32'h99 || b.rs2_data_o !== 32'h33)
      begin bad++; $display("FAIL refresh_other rs1=%h rs2=%h want 99/33", b.rs1_data_o, b.rs2_data_o); end
    b.ex_ready_i = 1; cyc(); b.ex_ready_i = 0;
  endtask

  task automatic test_back_to_back();
    b.ex_ready_i = 1; b.instr_i = 32'h00700213; b.instr_valid_i = 1; #1;
    total++; if (b.instr_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready0 got=%b want=1", b.instr_ready_o); end
    cyc();
    total++; if (b.imm_o !== 32'd7 || b.rd_o !== 5'd4) begin bad++; $display("FAIL b2b_first imm=%h rd=%0d want 7/4", b.imm_o, b.rd_o); end
    b.instr_i = 32'hFFF00293; #1;
    total++; if (b.instr_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready1 got=%b want=1", b.instr_ready_o); end
    cyc();
    total++; if (b.dec_valid_o !== 1'b1 || b.imm_o !== 32'hFFFFFFFF || b.rd_o !== 5'd5)
      begin bad++; $display("FAIL b2b_second vld=%b imm=%h rd=%0d want 1/ffffffff/5", b.dec_valid_o, b.imm_o, b.rd_o); end
    b.instr_valid_i = 0; cyc();
    total++; if (b.dec_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", b.dec_valid_o); end
    b.ex_ready_i = 0;
  endtask

  task automatic test_load_use();
    b.instr_i = 32'h0000A283; b.instr_valid_i = 1; cyc();
    b.instr_valid_i = 0;
    total++; if (b.mem_rd_o !== 1'b1 || b.mem_size_o !== 3'd2 || b.rd_o !== 5'd5 || b.alu_op_o !== 6'd1 || b.op_b_imm_o !== 1'b1)
      begin bad++; $display("FAIL lw_fields mrd=%b sz=%0d rd=%0d alu=%0d opb=%b want 1/2/5/1/1", b.mem_rd_o, b.mem_size_o, b.rd_o, b.alu_op_o, b.op_b_imm_o); end
    b.ex_ready_i = 1; cyc();
    b.instr_i = 32'h00528333; b.instr_valid_i = 1; #1;
    total++; if (b.instr_ready_o !== 1'b0) begin bad++; $display("FAIL lu_stall got=%b want=0", b.instr_ready_o); end
    cyc();
    total++; if (b.dec_valid_o !== 1'b0 || b.instr_ready_o !== 1'b1)
      begin bad++; $display("FAIL lu_bubble vld=%b rdy=%b want 0/1", b.dec_valid_o, b.instr_ready_o); end
    cyc();
    total++; if (b.dec_valid_o !== 1'b1 || b.rd_o !== 5'd6) begin bad++; $display("FAIL lu_accept vld=%b rd=%0d want 1/6", b.dec_valid_o, b.rd_o); end
    b.instr_valid_i = 0; cyc(); b.ex_ready_i = 0;
  endtask

  task automatic test_branch_flush();
    b.instr_i = 32'hFE208CE3; b.instr_valid_i = 1; cyc();
    b.instr_valid_i = 0;
    total++; if (b.branch_o !== 1'b1 || b.alu_op_o !== 6'd11 || b.imm_o !== 32'hFFFFFFF8 || b.rd_we_o !== 1'b0)
      begin bad++; $display("FAIL branch br=%b alu=%0d imm=%h we=%b want 1/11/fffffff8/0", b.branch_o, b.alu_op_o, b.imm_o, b.rd_we_o); end
    b.flush_i = 1; b.instr_i = 32'h00700213; b.instr_valid_i = 1; #1;
    total++; if (b.instr_ready_o !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", b.instr_ready_o); end
    cyc();
    b.flush_i = 0; b.instr_valid_i = 0;
    total++; if (b.dec_valid_o !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b want=0", b.dec_valid_o); end
    cyc();
    total++; if (b.dec_valid_o !== 1'b0) begin bad++; $display("FAIL flush_noaccept got=%b want=0", b.dec_valid_o); end
  endtask

  task automatic test_illegal();
    logic [31:0] vec [9];
    logic        ill_exp [9];
    logic        we_exp [9];
    logic [5:0]  alu_exp [9];
    vec     = '{32'h402081B3, 32'h400011B3, 32'h0000007F, 32'h00002063, 32'h4010D093,
                32'h40101093, 32'h0020C1B3, 32'h02208133, 32'h00100013};
    ill_exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    we_exp  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    alu_exp = '{6'd10, 6'd0, 6'd0, 6'd0, 6'd7, 6'd0, 6'd5, 6'd0, 6'd1};
    b.ex_ready_i = 1;
    for (int i = 0; i < 9; i++) begin
      b.instr_i = vec[i]; b.instr_valid_i = 1; cyc();
      total++; if (b.illegal_o !== ill_exp[i] || b.rd_we_o !== we_exp[i] || b.branch_o !== 1'b0)
        begin bad++; $display("FAIL illegal_%0d ill=%b we=%b br=%b want %b/%b/0", i, b.illegal_o, b.rd_we_o, b.branch_o, ill_exp[i], we_exp[i]); end
      if (!ill_exp[i]) begin
        total++; if (b.alu_op_o !== alu_exp[i]) begin bad++; $display("FAIL alu_%0d got=%0d want=%0d", i, b.alu_op_o, alu_exp[i]); end
      end
    end
    b.instr_valid_i = 0; cyc(); b.ex_ready_i = 0;
  endtask

  task automatic test_rv32e();
    logic [31:0] vec [4];
    logic        ill_exp [4];
    logic        we_exp [4];
    vec     = '{32'h00100813, 32'h0000007F, 32'h00500093, 32'h010080B3};
    ill_exp = '{1'b1, 1'b1, 1'b0, 1'b1};
    we_exp  = '{1'b0, 1'b0, 1'b1, 1'b0};
    e.ex_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      e.instr_i = vec[i]; e.instr_valid_i = 1; cyc();
      total++; if (e.illegal_o !== ill_exp[i] || e.rd_we_o !== we_exp[i] || e.dec_valid_o !== 1'b1)
        begin bad++; $display("FAIL rv32e_%0d ill=%b we=%b vld=%b want %b/%b/1", i, e.illegal_o, e.rd_we_o, e.dec_valid_o, ill_exp[i], we_exp[i]); end
    end
    e.instr_valid_i = 0; cyc(); e.ex_ready_i = 0;
  endtask

  task automatic test_async_reset();
    b.instr_i = 32'h00500093; b.instr_valid_i = 1; cyc();
    b.instr_valid_i = 0;
    total++; if (b.dec_valid_o !== 1'b1) begin bad++; $display("FAIL areset_pre got=%b want=1", b.dec_valid_o); end
    #3 rst_ni = 0; #1;
    total++; if (b.dec_valid_o !== 1'b0 || b.imm_o !== 32'd0 || b.instr_ready_o !== 1'b0)
      begin bad++; $display("FAIL areset_drop vld=%b imm=%h rdy=%b want 0/0/0", b.dec_valid_o, b.imm_o, b.instr_ready_o); end
    @(negedge clk_i) rst_ni = 1;
    cyc();
    b.instr_i = 32'h002081B3; b.instr_valid_i = 1; cyc();
    b.instr_valid_i = 0;
    total++; if (b.rs1_data_o !== 32'd0 || b.rs2_data_o !== 32'd0)
      begin bad++; $display("FAIL areset_rf rs1=%h rs2=%h want 0/0", b.rs1_data_o, b.rs2_data_o); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_operand_read();
    test_refresh();
    test_back_to_back();
    test_load_use();
    test_branch_flush();
    test_illegal();
    test_rv32e();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
